// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem_resp data-memory responder: MMIO word map,
// FSM state encoding and the read lane-mask helper.
package dmem_pkg;

  localparam int unsigned MMIO_SEL_BIT = 15;
  localparam int unsigned MMIO_WAW     = 14;

  // MMIO word addresses as seen on dat_a[15:2]
  localparam logic [MMIO_WAW-1:0] MMIO_CYCLE   = 14'h2000;
  localparam logic [MMIO_WAW-1:0] MMIO_TOHOST  = 14'h2001;
  localparam logic [MMIO_WAW-1:0] MMIO_CONSOLE = 14'h2002;

  typedef enum logic [1:0] {
    CLR  = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  function automatic logic [31:0] lane_mask(input logic [3:0] en);
    return {{8{en[3]}}, {8{en[2]}}, {8{en[1]}}, {8{en[0]}}};
  endfunction

endpackage

// File: rtl/dmem_con_fifo.sv
// Console byte FIFO: push with overflow flag, valid/ready pop.
// DEPTH must be a power of two, at least 2.
module dmem_con_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    push,
  input  logic [DW-1:0]           push_data,
  output logic                    full,
  output logic                    ovf,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    vld,
  output logic [DW-1:0]           data,
  input  logic                    rdy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] slot_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop_c;
  logic          push_ok_c;

  assign full      = (count == CW'(DEPTH));
  assign vld       = (count != '0);
  assign data      = vld ? slot_q[rd_ptr] : '0;
  assign pop_c     = vld && rdy;
  // A pop in the same cycle frees the slot a push into a full FIFO needs
  assign push_ok_c = push && (!full || pop_c);

  always_ff @(posedge clk) begin
    if (push_ok_c) slot_q[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)     rd_ptr <= rd_ptr + PW'(1);
      if (push && !push_ok_c) ovf <= 1'b1;
      case ({push_ok_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder for the core dat_* port: zero-filled byte-lane SRAM plus
// MMIO (CYCLE, TOHOST, CONSOLE). Console FIFO built only with `DMEM_CONSOLE_EN.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int unsigned AW        = 14,
  parameter int unsigned CON_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] dat_a,
  input  logic [3:0]  dat_we,
  input  logic [31:0] dat_wd,
  input  logic [3:0]  dat_re,
  output logic [31:0] dat_rd,
  output logic        busy,
  output logic        done,
  output logic [30:0] exit_code,
  output logic        con_vld,
  output logic [7:0]  con_data,
  input  logic        con_rdy
);

  localparam int unsigned NWORDS = 2 ** AW;

  state_e                state;
  state_e                state_nxt;
  logic [AW-1:0]         fill_idx;
  logic [31:0]           cycle_cnt;
  logic [31:0]           mem [NWORDS];
  logic [31:0]           con_status;

  logic                  is_mmio;
  logic [MMIO_WAW-1:0]   mmio_word;
  logic [AW-1:0]         word_idx;
  logic                  tohost_hit;

  logic                  mem_wr;
  logic [AW-1:0]         wr_idx;
  logic [31:0]           wr_data;
  logic [3:0]            wr_be;
  logic                  rd_load;
  logic [31:0]           rd_word;
  logic                  con_push;
  logic                  unused_ok;

  assign is_mmio    = dat_a[MMIO_SEL_BIT];
  assign mmio_word  = dat_a[15:2];
  assign word_idx   = dat_a[AW+1:2];
  assign tohost_hit = (state == RUN) && is_mmio && (mmio_word == MMIO_TOHOST) &&
                      (dat_we == 4'hF) && dat_wd[0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= CLR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLR:     if (fill_idx == {AW{1'b1}}) state_nxt = RUN;
      RUN:     if (tohost_hit) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = CLR;
    endcase
  end

  // Request decode: CLR owns the write port; HALT keeps reads but drops writes
  always_comb begin
    mem_wr   = 1'b0;
    wr_idx   = word_idx;
    wr_data  = dat_wd;
    wr_be    = dat_we;
    rd_load  = 1'b0;
    rd_word  = '0;
    con_push = 1'b0;
    case (state)
      CLR: begin
        mem_wr  = 1'b1;
        wr_idx  = fill_idx;
        wr_data = '0;
        wr_be   = 4'hF;
      end
      RUN, HALT: begin
        rd_load = |dat_re;
        if (!is_mmio) begin
          rd_word = mem[word_idx];
        end else begin
          case (mmio_word)
            MMIO_CYCLE:   rd_word = cycle_cnt;
            MMIO_TOHOST:  rd_word = {exit_code, done};
            MMIO_CONSOLE: rd_word = con_status;
            default:      rd_word = '0;
          endcase
        end
        if (state == RUN) begin
          mem_wr   = !is_mmio && (|dat_we);
          con_push = is_mmio && (mmio_word == MMIO_CONSOLE) && dat_we[0];
        end
      end
      default: ;
    endcase
  end

  // Byte-lane write port; the registered read below sees the pre-write word
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fill_idx  <= '0;
      cycle_cnt <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
      exit_code <= '0;
      dat_rd    <= '0;
    end else begin
      busy <= (state_nxt == CLR);
      if (state == CLR) fill_idx  <= fill_idx + AW'(1);
      if (state == RUN) cycle_cnt <= cycle_cnt + 32'd1;
      if (tohost_hit) begin
        done      <= 1'b1;
        exit_code <= dat_wd[31:1];
      end
      if (rd_load) dat_rd <= rd_word & lane_mask(dat_re);
    end
  end

`ifdef DMEM_CONSOLE_EN
  localparam int unsigned CON_CW = $clog2(CON_DEPTH) + 1;

  logic [CON_CW-1:0] con_count;
  logic              con_ovf;
  logic              con_full;

  dmem_con_fifo #(
    .DEPTH (CON_DEPTH),
    .DW    (8)
  ) u_con_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (con_push),
    .push_data (dat_wd[7:0]),
    .full      (con_full),
    .ovf       (con_ovf),
    .count     (con_count),
    .vld       (con_vld),
    .data      (con_data),
    .rdy       (con_rdy)
  );

  // Count field is 3 bits wide and saturates for deeper FIFOs
  assign con_status = {23'b0, con_ovf, 5'b0,
                       (32'(con_count) > 32'd7) ? 3'd7 : 3'(con_count)};
  assign unused_ok  = ^{dat_a, con_full};
`else
  assign con_vld    = 1'b0;
  assign con_data   = '0;
  assign con_status = '0;
  assign unused_ok  = ^{dat_a, con_rdy, con_push};
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp (AW=4): directed steps plus randomized
// memory traffic against a word/byte-array reference model.
module tb_dmem_resp;

  localparam int unsigned AW = 4;
  localparam int unsigned NW = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] dat_a;
  logic [3:0]  dat_we;
  logic [31:0] dat_wd;
  logic [3:0]  dat_re;
  logic [31:0] dat_rd;
  logic        busy;
  logic        done;
  logic [30:0] exit_code;
  logic        con_vld;
  logic [7:0]  con_data;
  logic        con_rdy;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model [NW];
  logic [31:0] exp_rd;
  logic [31:0] c0;
  logic [7:0]  got [$];

  dmem_resp #(.AW(AW), .CON_DEPTH(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .dat_a     (dat_a),
    .dat_we    (dat_we),
    .dat_wd    (dat_wd),
    .dat_re    (dat_re),
    .dat_rd    (dat_rd),
    .busy      (busy),
    .done      (done),
    .exit_code (exit_code),
    .con_vld   (con_vld),
    .con_data  (con_data),
    .con_rdy   (con_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mask_of(input logic [3:0] en);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (en[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  // One request: drive, take one rising edge, sample 1ns later
  task automatic req(input logic [15:0] a, input logic [3:0] we,
                     input logic [31:0] wd, input logic [3:0] re);
    dat_a  = a;
    dat_we = we;
    dat_wd = wd;
    dat_re = re;
    @(posedge clk);
    #1;
    dat_we = '0;
    dat_re = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_fill(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(n), 32'(NW));
  endtask

  task automatic drain_check(input string tag, input logic [7:0] first);
    got.delete();
    con_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (con_vld === 1'b1) got.push_back(con_data);
      @(posedge clk);
      #1;
    end
    con_rdy = 1'b0;
    chk({tag, "_n"}, 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk(tag, (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(first + 8'(i)));
    end
    chk({tag, "_empty"}, 32'(con_vld), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [3:0]  we;
    logic [3:0]  re;
    logic [31:0] wd;
    int          idx;

    rstn = 1'b0; dat_a = '0; dat_we = '0; dat_wd = '0; dat_re = '0; con_rdy = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_exit", 32'(exit_code), 32'd0);
    chk("rst_dat_rd", dat_rd, 32'd0);
    chk("rst_con_vld", 32'(con_vld), 32'd0);
    chk("rst_con_data", 32'(con_data), 32'd0);

    @(negedge clk);
    rstn = 1'b1;
    wait_fill("clr_len");
    for (int i = 0; i < int'(NW); i++) begin
      model[i] = '0;
      req(16'(i * 4), 4'h0, 32'h0, 4'hF);
      chk("zero_fill", dat_rd, 32'h0);
    end
    exp_rd = '0;

    // Random memory traffic; addresses above the array alias by wrap-around
    for (int n = 0; n < 300; n++) begin
      a   = 16'($urandom) & 16'h7FFF;
      we  = 4'($urandom);
      re  = 4'($urandom);
      wd  = $urandom;
      idx = int'(a[5:2]);
      if (re != 4'h0) exp_rd = model[idx] & mask_of(re);
      for (int b = 0; b < 4; b++) if (we[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
      req(a, we, wd, re);
      chk("rand_rd", dat_rd, exp_rd);
    end

    req(16'h0010, 4'hF, 32'hDEADBEEF, 4'h0);
    req(16'h0010, 4'h0, 32'h0, 4'b0100);
    chk("lane_rd", dat_rd, 32'h00AD0000);
    req(16'h0010, 4'hF, 32'h11223344, 4'hF);
    chk("rd_before_wr", dat_rd, 32'hDEADBEEF);
    req(16'h0010, 4'h0, 32'h0, 4'hF);
    chk("wr_then_rd", dat_rd, 32'h11223344);
    model[4] = 32'h11223344;
    req(16'h0000, 4'hF, 32'h00000055, 4'h0);
    model[0] = 32'h00000055;
    req(16'h0040, 4'h0, 32'h0, 4'hF);
    chk("alias", dat_rd, 32'h00000055);
    req(16'h0010, 4'h0, 32'h0, 4'h0);
    chk("rd_hold", dat_rd, 32'h00000055);

    req(16'h8000, 4'h0, 32'h0, 4'hF);
    c0 = dat_rd;
    idle(5);
    req(16'h8000, 4'h0, 32'h0, 4'hF);
    chk("cycle_delta", dat_rd - c0, 32'd6);
    req(16'h800C, 4'hF, 32'hFFFFFFFF, 4'hF);
    chk("mmio_unmapped", dat_rd, 32'h0);

`ifdef DMEM_CONSOLE_EN
    for (int k = 0; k < 5; k++) req(16'h8008, 4'h1, 32'(8'h41 + 8'(k)), 4'h0);
    req(16'h8008, 4'h0, 32'h0, 4'hF);
    chk("con_status", dat_rd, 32'h00000104);
    chk("con_head_vld", 32'(con_vld), 32'd1);
    chk("con_head", 32'(con_data), 32'h41);
    drain_check("con_drain", 8'h41);
    for (int k = 0; k < 4; k++) req(16'h8008, 4'h1, 32'(8'h57 + 8'(k)), 4'h0);
    con_rdy = 1'b1;
    req(16'h8008, 4'h1, 32'h21, 4'h0);
    con_rdy = 1'b0;
    req(16'h8008, 4'h0, 32'h0, 4'hF);
    chk("con_full_pushpop", dat_rd, 32'h00000104);
    got.delete();
    con_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (con_vld === 1'b1) got.push_back(con_data);
      @(posedge clk);
      #1;
    end
    con_rdy = 1'b0;
    chk("con_pp_n", 32'(got.size()), 32'd4);
    chk("con_pp_last", (got.size() == 4) ? 32'(got[3]) : 32'hFFFF_FFFF, 32'h21);
    chk("con_pp_first", (got.size() > 0) ? 32'(got[0]) : 32'hFFFF_FFFF, 32'h58);
`else
    req(16'h8008, 4'hF, 32'h41, 4'h0);
    req(16'h8008, 4'h0, 32'h0, 4'hF);
    chk("con_off_rd", dat_rd, 32'h0);
    chk("con_off_vld", 32'(con_vld), 32'd0);
    con_rdy = 1'b1;
    idle(1);
    chk("con_off_data", 32'(con_data), 32'd0);
    con_rdy = 1'b0;
`endif

    req(16'h8004, 4'h0, 32'h0, 4'hF);
    chk("tohost_rd0", dat_rd, 32'h0);
    req(16'h8004, 4'hF, 32'h0000002A, 4'h0);
    chk("tohost_even", 32'(done), 32'd0);
    req(16'h8004, 4'h1, 32'h0000002B, 4'h0);
    chk("tohost_partial", 32'(done), 32'd0);
    req(16'h8004, 4'hF, 32'h0000002B, 4'h0);
    chk("done", 32'(done), 32'd1);
    chk("exit_code", 32'(exit_code), 32'h15);
    req(16'h8004, 4'h0, 32'h0, 4'hF);
    chk("tohost_rd", dat_rd, 32'h0000002B);

    req(16'h0000, 4'hF, 32'hCAFEF00D, 4'h0);
    req(16'h0000, 4'h0, 32'h0, 4'hF);
    chk("halt_no_wr", dat_rd, model[0]);
    req(16'h8004, 4'hF, 32'h00000007, 4'h0);
    chk("halt_exit_keep", 32'(exit_code), 32'h15);
`ifdef DMEM_CONSOLE_EN
    req(16'h8008, 4'h1, 32'h51, 4'h0);
    idle(1);
    chk("halt_no_push", 32'(con_vld), 32'd0);
`endif
    req(16'h8000, 4'h0, 32'h0, 4'hF);
    c0 = dat_rd;
    idle(3);
    req(16'h8000, 4'h0, 32'h0, 4'hF);
    chk("cycle_frozen", dat_rd, c0);

    // Reset partway through the fill restarts it from index 0
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst2_done", 32'(done), 32'd0);
    chk("rst2_dat_rd", dat_rd, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    idle(7);
    chk("mid_clr_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_clr_rst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    wait_fill("clr_restart");
    for (int i = 0; i < int'(NW); i++) begin
      req(16'(i * 4), 4'h0, 32'h0, 4'hF);
      chk("refill_zero", dat_rd, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
